// File: rtl/sci_acc_ingress_arb.sv
// sci_acc_ingress_arb
// Multi-channel ingress stage for accelerator op packets. Each of NUM_CH
// producers writes {data, one-hot mode, resolution} into its own circular
// FIFO; packets with a non-one-hot mode, or that arrive while their FIFO is
// full, are dropped and counted. A round-robin arbiter pops one packet per
// cycle into a registered valid/ready output stage.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   in_pkt_valid        per-channel packet valid
//   in_op_pkt__data/mode/res  flattened per-channel payload (channel i at slice i)
//   in_ready            per-channel FIFO-not-full
//   in_pkt_dropd        one-cycle drop pulse per channel (registered)
//   out_pkt_valid, out_op_pkt__data/mode/res, out_ch   registered output packet
//   out_ready           downstream accept
//   drop_cnt            saturating total of dropped packets
module sci_acc_ingress_arb #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_MODES  = 4,
  parameter int RES_WIDTH  = 8,
  parameter int NUM_CH     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_CNT_W = 16,
  localparam int CH_W      = $clog2(NUM_CH)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_CH-1:0]               in_pkt_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0]    in_op_pkt__data,
  input  logic [NUM_CH*NUM_MODES-1:0]     in_op_pkt__mode,
  input  logic [NUM_CH*RES_WIDTH-1:0]     in_op_pkt__res,
  output logic [NUM_CH-1:0]               in_ready,
  output logic [NUM_CH-1:0]               in_pkt_dropd,
  output logic                            out_pkt_valid,
  output logic [DATA_WIDTH-1:0]           out_op_pkt__data,
  output logic [NUM_MODES-1:0]            out_op_pkt__mode,
  output logic [RES_WIDTH-1:0]            out_op_pkt__res,
  output logic [CH_W-1:0]                 out_ch,
  input  logic                            out_ready,
  output logic [DROP_CNT_W-1:0]           drop_cnt
);

  localparam int PW = DATA_WIDTH + NUM_MODES + RES_WIDTH;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int NW = CH_W + 1;
  localparam int SW = DROP_CNT_W + NW;

  function automatic logic is_onehot(input logic [NUM_MODES-1:0] m);
    int n;
    n = 0;
    for (int b = 0; b < NUM_MODES; b++) n += int'(m[b]);
    return (n == 1);
  endfunction

  function automatic logic [NW-1:0] popcount(input logic [NUM_CH-1:0] v);
    logic [NW-1:0] n;
    n = '0;
    for (int b = 0; b < NUM_CH; b++) n = n + NW'(v[b]);
    return n;
  endfunction

  // Saturating accumulate: the counter sticks at all-ones instead of wrapping.
  function automatic logic [DROP_CNT_W-1:0] sat_add(input logic [DROP_CNT_W-1:0] a,
                                                   input logic [NW-1:0] b);
    logic [SW-1:0] sum;
    sum = SW'(a) + SW'(b);
    if (sum > SW'({DROP_CNT_W{1'b1}})) return '1;
    return sum[DROP_CNT_W-1:0];
  endfunction

  logic [PW-1:0]     mem    [NUM_CH][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr [NUM_CH];
  logic [AW-1:0]     rd_ptr [NUM_CH];
  logic [CW-1:0]     cnt    [NUM_CH];
  logic [PW-1:0]     wr_pkt [NUM_CH];
  logic [PW-1:0]     head   [NUM_CH];
  logic [NUM_CH-1:0] full, nonempty, push, drop, pop;
  logic [CH_W-1:0]   rr_ptr, grant;
  logic              found, load;

  // Output stage registers
  logic              vld_p0;
  logic [PW-1:0]     pkt_p0;
  logic [CH_W-1:0]   ch_p0;

  // Ingress classification: fullness is taken from the registered count, so
  // a full FIFO refuses a push even if it is popped at the same edge.
  always_comb begin
    full     = '0;
    nonempty = '0;
    push     = '0;
    drop     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      wr_pkt[i]   = {in_op_pkt__data[i*DATA_WIDTH +: DATA_WIDTH],
                     in_op_pkt__mode[i*NUM_MODES +: NUM_MODES],
                     in_op_pkt__res[i*RES_WIDTH +: RES_WIDTH]};
      head[i]     = mem[i][rd_ptr[i]];
      full[i]     = (cnt[i] == CW'(FIFO_DEPTH));
      nonempty[i] = (cnt[i] != '0);
      push[i]     = in_pkt_valid[i] && is_onehot(in_op_pkt__mode[i*NUM_MODES +: NUM_MODES])
                    && !full[i];
      drop[i]     = in_pkt_valid[i] && !push[i];
    end
  end

  assign in_ready = ~full;

  // Round-robin grant: first non-empty channel above rr_ptr, then wrap to
  // the lowest non-empty channel at or below it.
  always_comb begin
    grant = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && nonempty[i] && (CH_W'(i) > rr_ptr)) begin
        found = 1'b1;
        grant = CH_W'(i);
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!found && nonempty[i] && (CH_W'(i) <= rr_ptr)) begin
        found = 1'b1;
        grant = CH_W'(i);
      end
    end
  end

  always_comb begin
    load = (!vld_p0 || out_ready) && (|nonempty);
    pop  = '0;
    for (int i = 0; i < NUM_CH; i++) pop[i] = load && (grant == CH_W'(i));
  end

  // FIFO storage carries data only and needs no reset
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem[i][wr_ptr[i]] <= wr_pkt[i];
    end
  end

  // Pointers, counts, drop accounting, arbiter state and output stage
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        cnt[i]    <= '0;
      end
      in_pkt_dropd <= '0;
      drop_cnt     <= '0;
      rr_ptr       <= CH_W'(NUM_CH - 1);
      vld_p0       <= 1'b0;
      pkt_p0       <= '0;
      ch_p0        <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push[i]) wr_ptr[i] <= wr_ptr[i] + AW'(1);
        if (pop[i])  rd_ptr[i] <= rd_ptr[i] + AW'(1);
        case ({push[i], pop[i]})
          2'b10:   cnt[i] <= cnt[i] + CW'(1);
          2'b01:   cnt[i] <= cnt[i] - CW'(1);
          default: cnt[i] <= cnt[i];
        endcase
      end
      in_pkt_dropd <= drop;
      drop_cnt     <= sat_add(drop_cnt, popcount(drop));
      if (load) begin
        vld_p0 <= 1'b1;
        pkt_p0 <= head[grant];
        ch_p0  <= grant;
        rr_ptr <= grant;
      end else if (out_ready) begin
        vld_p0 <= 1'b0;
      end
    end
  end

  assign out_pkt_valid    = vld_p0;
  assign out_op_pkt__data = pkt_p0[PW-1 -: DATA_WIDTH];
  assign out_op_pkt__mode = pkt_p0[RES_WIDTH +: NUM_MODES];
  assign out_op_pkt__res  = pkt_p0[RES_WIDTH-1:0];
  assign out_ch           = ch_p0;

endmodule

// File: tb/tb_sci_acc_ingress_arb.sv
// Directed bench for sci_acc_ingress_arb (4 channels, depth 4, 4-bit drop
// counter). One hand-written single-packet sequence, then a per-cycle table
// of inputs and expected post-edge outputs.
module tb_sci_acc_ingress_arb;
  localparam int DW = 32, MW = 4, RW = 8, NC = 4, DEPTH = 4, DCW = 4;
  localparam logic [15:0] M = 16'h8421;  // ch0=0001 ch1=0010 ch2=0100 ch3=1000

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NC-1:0]     in_pkt_valid;
  logic [NC*DW-1:0]  in_op_pkt__data;
  logic [NC*MW-1:0]  in_op_pkt__mode;
  logic [NC*RW-1:0]  in_op_pkt__res;
  logic [NC-1:0]     in_ready;
  logic [NC-1:0]     in_pkt_dropd;
  logic              out_pkt_valid;
  logic [DW-1:0]     out_op_pkt__data;
  logic [MW-1:0]     out_op_pkt__mode;
  logic [RW-1:0]     out_op_pkt__res;
  logic [1:0]        out_ch;
  logic              out_ready;
  logic [DCW-1:0]    drop_cnt;

  sci_acc_ingress_arb #(
    .DATA_WIDTH(DW), .NUM_MODES(MW), .RES_WIDTH(RW),
    .NUM_CH(NC), .FIFO_DEPTH(DEPTH), .DROP_CNT_W(DCW)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_pkt_valid(in_pkt_valid),
    .in_op_pkt__data(in_op_pkt__data),
    .in_op_pkt__mode(in_op_pkt__mode),
    .in_op_pkt__res(in_op_pkt__res),
    .in_ready(in_ready),
    .in_pkt_dropd(in_pkt_dropd),
    .out_pkt_valid(out_pkt_valid),
    .out_op_pkt__data(out_op_pkt__data),
    .out_op_pkt__mode(out_op_pkt__mode),
    .out_op_pkt__res(out_op_pkt__res),
    .out_ch(out_ch),
    .out_ready(out_ready),
    .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] vld;
    logic [15:0] mode;
    logic [7:0] tag;
    logic       ordy;
    logic       eov;
    logic [1:0] ech;
    logic [7:0] etag;
    logic [3:0] erdy;
    logic [3:0] edrp;
    logic [3:0] edc;
  } vec_t;

  vec_t tbl[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] pkt_data(input logic [7:0] tag, input int ch);
    return {16'hC0DE, tag, 8'(ch)};
  endfunction

  function automatic logic [7:0] pkt_res(input logic [7:0] tag, input int ch);
    return {tag[3:0], 4'(ch)};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] v, input logic [15:0] m,
                     input logic [7:0] t, input logic o, input logic eov,
                     input logic [1:0] ech, input logic [7:0] etag,
                     input logic [3:0] erdy, input logic [3:0] edrp, input logic [3:0] edc);
    vec_t x;
    x.rst = r; x.vld = v; x.mode = m; x.tag = t; x.ordy = o;
    x.eov = eov; x.ech = ech; x.etag = etag; x.erdy = erdy; x.edrp = edrp; x.edc = edc;
    tbl.push_back(x);
  endtask

  task automatic drive(input vec_t x);
    rst_n        = !x.rst;
    in_pkt_valid = x.vld;
    in_op_pkt__mode = x.mode;
    for (int ch = 0; ch < NC; ch++) begin
      in_op_pkt__data[ch*DW +: DW] = pkt_data(x.tag, ch);
      in_op_pkt__res[ch*RW +: RW]  = pkt_res(x.tag, ch);
    end
    out_ready = x.ordy;
  endtask

  initial begin
    rst_n = 1'b0;
    in_pkt_valid = '0;
    in_op_pkt__data = '0;
    in_op_pkt__mode = '0;
    in_op_pkt__res = '0;
    out_ready = 1'b0;

    // reset
    add(1'b1, 4'h0, M, 8'd0, 1'b0, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'd0);
    // all channels valid for 3 cycles, out_ready high: round-robin interleave
    add(1'b0, 4'hF, M, 8'd1, 1'b1, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'hF, M, 8'd2, 1'b1, 1'b1, 2'd0, 8'd1, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'hF, M, 8'd3, 1'b1, 1'b1, 2'd1, 8'd1, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd2, 8'd1, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd3, 8'd1, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd0, 8'd2, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd1, 8'd2, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd2, 8'd2, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd3, 8'd2, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd0, 8'd3, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd1, 8'd3, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd2, 8'd3, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd3, 8'd3, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'd0);
    // ch0 packet parks in the output, then ch2 sends 6 with out_ready low
    add(1'b1, 4'h0, M, 8'd0, 1'b0, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h1, M, 8'd9, 1'b0, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h4, M, 8'd1, 1'b0, 1'b1, 2'd0, 8'd9, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h4, M, 8'd2, 1'b0, 1'b1, 2'd0, 8'd9, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h4, M, 8'd3, 1'b0, 1'b1, 2'd0, 8'd9, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h4, M, 8'd4, 1'b0, 1'b1, 2'd0, 8'd9, 4'hB, 4'h0, 4'd0);
    add(1'b0, 4'h4, M, 8'd5, 1'b0, 1'b1, 2'd0, 8'd9, 4'hB, 4'h4, 4'd1);
    add(1'b0, 4'h4, M, 8'd6, 1'b0, 1'b1, 2'd0, 8'd9, 4'hB, 4'h4, 4'd2);
    add(1'b0, 4'h0, M, 8'd0, 1'b0, 1'b1, 2'd0, 8'd9, 4'hB, 4'h0, 4'd2);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd2, 8'd1, 4'hF, 4'h0, 4'd2);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd2, 8'd2, 4'hF, 4'h0, 4'd2);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd2, 8'd3, 4'hF, 4'h0, 4'd2);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd2, 8'd4, 4'hF, 4'h0, 4'd2);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'd2);
    // illegal modes 0000 and 0110 on ch1
    add(1'b0, 4'h2, 16'h8401, 8'd7, 1'b1, 1'b0, 2'd0, 8'd0, 4'hF, 4'h2, 4'd3);
    add(1'b0, 4'h2, 16'h8461, 8'd7, 1'b1, 1'b0, 2'd0, 8'd0, 4'hF, 4'h2, 4'd4);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'd4);
    // fill all FIFOs with out_ready low, then simultaneous drops to saturation
    add(1'b0, 4'hF, M, 8'd1, 1'b0, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'd4);
    add(1'b0, 4'hF, M, 8'd2, 1'b0, 1'b1, 2'd3, 8'd1, 4'hF, 4'h0, 4'd4);
    add(1'b0, 4'hF, M, 8'd3, 1'b0, 1'b1, 2'd3, 8'd1, 4'hF, 4'h0, 4'd4);
    add(1'b0, 4'hF, M, 8'd4, 1'b0, 1'b1, 2'd3, 8'd1, 4'h8, 4'h0, 4'd4);
    add(1'b0, 4'hF, M, 8'd5, 1'b0, 1'b1, 2'd3, 8'd1, 4'h0, 4'h7, 4'd7);
    add(1'b0, 4'hF, M, 8'd6, 1'b0, 1'b1, 2'd3, 8'd1, 4'h0, 4'hF, 4'd11);
    add(1'b0, 4'hF, M, 8'd7, 1'b0, 1'b1, 2'd3, 8'd1, 4'h0, 4'hF, 4'd15);
    add(1'b0, 4'hF, M, 8'd8, 1'b0, 1'b1, 2'd3, 8'd1, 4'h0, 4'hF, 4'd15);
    add(1'b0, 4'h0, M, 8'd0, 1'b0, 1'b1, 2'd3, 8'd1, 4'h0, 4'h0, 4'd15);
    // move the pointer to ch0, then reset mid-operation
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd0, 8'd1, 4'h1, 4'h0, 4'd15);
    add(1'b1, 4'hF, M, 8'd9, 1'b0, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h3, M, 8'd3, 1'b1, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd0, 8'd3, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b1, 2'd1, 8'd3, 4'hF, 4'h0, 4'd0);
    add(1'b0, 4'h0, M, 8'd0, 1'b1, 1'b0, 2'd0, 8'd0, 4'hF, 4'h0, 4'd0);

    // initial reset state
    @(posedge clk); #1;
    chk("reset ovld",  64'(out_pkt_valid), 64'(1'b0));
    chk("reset data",  64'(out_op_pkt__data), 64'(32'h0));
    chk("reset mode",  64'(out_op_pkt__mode), 64'(4'h0));
    chk("reset res",   64'(out_op_pkt__res), 64'(8'h0));
    chk("reset och",   64'(out_ch), 64'(2'd0));
    chk("reset rdy",   64'(in_ready), 64'(4'hF));
    chk("reset drp",   64'(in_pkt_dropd), 64'(4'h0));
    chk("reset dcnt",  64'(drop_cnt), 64'(4'd0));

    // single packet on ch0: valid on the output two edges after presentation
    rst_n = 1'b1;
    out_ready = 1'b1;
    in_pkt_valid = 4'b0001;
    in_op_pkt__data[31:0] = 32'h1234_5678;
    in_op_pkt__mode[3:0]  = 4'b0010;
    in_op_pkt__res[7:0]   = 8'h0A;
    @(posedge clk); #1;
    chk("single ovld e1", 64'(out_pkt_valid), 64'(1'b0));
    in_pkt_valid = 4'b0000;
    @(posedge clk); #1;
    chk("single ovld e2", 64'(out_pkt_valid), 64'(1'b1));
    chk("single data",    64'(out_op_pkt__data), 64'(32'h1234_5678));
    chk("single mode",    64'(out_op_pkt__mode), 64'(4'b0010));
    chk("single res",     64'(out_op_pkt__res), 64'(8'h0A));
    chk("single och",     64'(out_ch), 64'(2'd0));
    chk("single dcnt",    64'(drop_cnt), 64'(4'd0));
    @(posedge clk); #1;
    chk("single ovld e3", 64'(out_pkt_valid), 64'(1'b0));

    // table vectors: inputs before the edge, outputs checked 1 time unit after
    for (int n = 0; n < tbl.size(); n++) begin
      vec_t r;
      logic [3:0] em;
      r = tbl[n];
      drive(r);
      @(posedge clk); #1;
      chk($sformatf("row%0d ovld", n), 64'(out_pkt_valid), 64'(r.eov));
      chk($sformatf("row%0d rdy", n),  64'(in_ready), 64'(r.erdy));
      chk($sformatf("row%0d drp", n),  64'(in_pkt_dropd), 64'(r.edrp));
      chk($sformatf("row%0d dcnt", n), 64'(drop_cnt), 64'(r.edc));
      if (r.eov) begin
        em = 4'b0001 << r.ech;
        chk($sformatf("row%0d och", n),  64'(out_ch), 64'(r.ech));
        chk($sformatf("row%0d data", n), 64'(out_op_pkt__data), 64'(pkt_data(r.etag, int'(r.ech))));
        chk($sformatf("row%0d mode", n), 64'(out_op_pkt__mode), 64'(em));
        chk($sformatf("row%0d res", n),  64'(out_op_pkt__res), 64'(pkt_res(r.etag, int'(r.ech))));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sci_acc_ingress_arb.md
Name: sci_acc_ingress_arb

Overview:
Multi-channel ingress stage for the accelerator's operation packets. It accepts op packets (data, one-hot mode, resolution) from NUM_CH independent producers and buffers each channel in its own FIFO. It drops packets with an illegal mode or that arrive while their FIFO is full. A round-robin arbiter forwards packets one at a time through a registered valid/ready output to the compute core.

Parameters:
DATA_WIDTH, 32, operand data width
NUM_MODES, 4, width of the one-hot mode field
RES_WIDTH, 8, resolution field width
NUM_CH, 4, number of input channels (>=2)
FIFO_DEPTH, 4, entries per channel FIFO (power of 2, >=2)
DROP_CNT_W, 16, width of the aggregate drop counter
CH_W, $clog2(NUM_CH), channel index width (derived, not overridable)

Ports:
clk  input  1  clock; all state updates on posedge
rst_n  input  1  synchronous active-low reset
in_pkt_valid  input  NUM_CH  per-channel packet valid
in_op_pkt__data  input  NUM_CH*DATA_WIDTH  flattened data; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
in_op_pkt__mode  input  NUM_CH*NUM_MODES  flattened mode
in_op_pkt__res  input  NUM_CH*RES_WIDTH  flattened resolution
in_ready  output  NUM_CH  per-channel FIFO not full
in_pkt_dropd  output  NUM_CH  registered one-cycle drop pulse per channel
out_pkt_valid  output  1  output packet valid
out_op_pkt__data  output  DATA_WIDTH  output data
out_op_pkt__mode  output  NUM_MODES  output mode
out_op_pkt__res  output  RES_WIDTH  output resolution
out_ch  output  CH_W  source channel of the output packet
out_ready  input  1  core accepts the packet
drop_cnt  output  DROP_CNT_W  total dropped packets, saturating

Behaviour:
- Reset (rst_n=0 at posedge) puts the block in this state:
  - all FIFOs empty; in_ready all 1s; in_pkt_dropd 0
  - out_pkt_valid 0; out payload and out_ch 0
  - drop_cnt 0; round-robin pointer = NUM_CH-1, so channel 0 has first priority
  - Reset mid-operation discards all buffered and output-held packets. No drop pulses or counts are produced for them.
- Ingress, per channel i, evaluated at each posedge with in_pkt_valid[i]=1:
  - Mode not one-hot (zero or multiple bits set): drop.
  - Else if FIFO i is full (count == FIFO_DEPTH, evaluated before this edge's pop): drop.
  - Else: push {data, mode, res}.
  - A full FIFO refuses a push even when it pops in the same cycle.
- in_ready[i] is the combinational decode of registered count < FIFO_DEPTH. Producers are not required to wait for ready; a packet presented while not ready is lost.
- Drop: in_pkt_dropd[i]=1 for the cycle after the dropping edge.
- drop_cnt adds the number of channels dropping at that edge (0..NUM_CH) and saturates at 2^DROP_CNT_W-1. It never wraps.
- FIFO: circular buffer with wrap-around pointers and a count of log2(FIFO_DEPTH)+1 bits. Simultaneous push and pop on a non-full, non-empty FIFO leaves the count unchanged.
- Output register load condition (posedge): (!out_pkt_valid || out_ready) && any FIFO non-empty.
  - Grant goes to the first non-empty channel after the RR pointer, searching upward with wrap.
  - The granted channel's head is popped into the output register; out_ch = grant; pointer = grant.
- If the load condition holds but all FIFOs are empty: out_pkt_valid goes to 0 when out_ready=1; otherwise it holds.
- While out_pkt_valid=1 and out_ready=0, payload and out_ch are held stable.
- Latency: a packet pushed at edge t into an empty system is valid on the output after edge t+1. A push and a pop on the same FIFO at the same edge cannot hit the same entry.
- Throughput: one packet per cycle with out_ready held high.
- No packet is reordered within a channel. Across channels, order follows the round-robin grants.

Test Plan:
- Single packet, ch0, data=0x1234_5678, mode=4'b0010, res=8'h0A -> out_pkt_valid high two edges after input; payload matches; out_ch=0; drop_cnt=0.
- All 4 channels hold valid for 3 cycles with out_ready=1 -> outputs interleave ch0,1,2,3,0,1,2,3,... with per-channel order preserved; 12 packets out; no drops.
- out_ready=0; ch2 sends 6 packets -> in_ready[2] deasserts after the 4th; packets 5 and 6 each produce a one-cycle in_pkt_dropd[2] pulse; drop_cnt=2. Release out_ready -> exactly 4 packets out.
- Illegal modes 4'b0000 and 4'b0110 on ch1 with the FIFO empty -> both dropped, not enqueued; drop_cnt increments by 1 each.
- Simultaneous drops: all 4 channels full and sending -> drop_cnt += 4 in one cycle. Preload drop_cnt near max (DROP_CNT_W=4) -> saturates at 15.
- Assert rst_n=0 for one cycle with FIFOs partially full and out_pkt_valid=1 -> after the edge: out_pkt_valid=0, in_ready=4'b1111, drop_cnt=0; the first subsequent grant goes to ch0.
